// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, mul/div FSM states,
// the ID/EX pipeline register layout and the default mul/div latency.
package ex_pkg;

  localparam int MD_ITER_DEF = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_MUL  = 4'd11,
    ALU_DIVU = 4'd12,
    ALU_REMU = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // All-zero value of this struct is the pipeline bubble.
  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [3:0]  aluc;
    logic        aluimm;
    logic [31:0] inA;
    logic [31:0] inB;
    logic [31:0] imm;
    logic [4:0]  srcA;
    logic [4:0]  srcB;
    logic [4:0]  destR;
    logic [3:0]  ins_type;
    logic [3:0]  ins_number;
  } idex_t;

  function automatic logic is_md(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Decode-side inputs, EX/MEM forwarding source and memory-stage outputs of
// the execute stage; master drives decode/forwarding, slave is the stage.
interface ex_stage_if;
  logic        id_wreg, id_m2reg, id_wmem;
  logic [3:0]  id_aluc;
  logic        id_aluimm;
  logic [31:0] id_inA, id_inB, id_imm;
  logic [4:0]  id_srcA, id_srcB, id_destR;
  logic        id_flush;
  logic [3:0]  ID_ins_type, ID_ins_number;

  logic        mem_wreg;
  logic [4:0]  mem_destR;
  logic [31:0] mem_aluR;

  logic        ex_wreg, ex_m2reg, ex_wmem, ex_zero;
  logic [4:0]  ex_destR;
  logic [31:0] ex_aluR, ex_inB;
  logic        ex_stall;
  logic [3:0]  EXE_ins_type, EXE_ins_number;

  modport master (
    output id_wreg, id_m2reg, id_wmem, id_aluc, id_aluimm, id_inA, id_inB, id_imm,
           id_srcA, id_srcB, id_destR, id_flush, ID_ins_type, ID_ins_number,
           mem_wreg, mem_destR, mem_aluR,
    input  ex_wreg, ex_m2reg, ex_wmem, ex_zero, ex_destR, ex_aluR, ex_inB,
           ex_stall, EXE_ins_type, EXE_ins_number
  );

  modport slave (
    input  id_wreg, id_m2reg, id_wmem, id_aluc, id_aluimm, id_inA, id_inB, id_imm,
           id_srcA, id_srcB, id_destR, id_flush, ID_ins_type, ID_ins_number,
           mem_wreg, mem_destR, mem_aluR,
    output ex_wreg, ex_m2reg, ex_wmem, ex_zero, ex_destR, ex_aluR, ex_inB,
           ex_stall, EXE_ins_type, EXE_ins_number
  );
endinterface

// File: rtl/md_unit.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per
// BUSY cycle. Holds the pipeline via stall_o until the result is ready.
module md_unit
  import ex_pkg::*;
#(
  parameter int MD_ITER = MD_ITER_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        stall_o,
  output logic [31:0] res_o
);
  localparam int CW = $clog2(MD_ITER + 1);

  md_state_e   state_q;
  logic [CW-1:0] cnt_q;
  // acc: product / partial remainder; x: multiplicand / dividend->quotient;
  // y: multiplier / divisor.
  logic [31:0] acc_q, x_q, y_q;
  logic [32:0] rsh, rdiff;
  logic        md_op;

  assign md_op = is_md(op_i);
  assign rsh   = {acc_q, x_q[31]};
  assign rdiff = rsh - {1'b0, y_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      case (state_q)
        MD_IDLE: if (md_op) begin
          state_q <= MD_BUSY;
          cnt_q   <= '0;
          acc_q   <= '0;
          x_q     <= a_i;
          y_q     <= b_i;
        end
        MD_BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(MD_ITER - 1)) state_q <= MD_DONE;
          // 32 bit-steps; any extra latency cycles just hold the result.
          if (int'(cnt_q) < 32) begin
            if (op_i == ALU_MUL) begin
              if (y_q[0]) acc_q <= acc_q + x_q;
              x_q <= x_q << 1;
              y_q <= y_q >> 1;
            end else if (!rdiff[32]) begin
              acc_q <= rdiff[31:0];
              x_q   <= {x_q[30:0], 1'b1};
            end else begin
              acc_q <= rsh[31:0];
              x_q   <= {x_q[30:0], 1'b0};
            end
          end
        end
        MD_DONE: state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign stall_o = md_op && (state_q != MD_DONE);

  always_comb begin
    res_o = '0;
    case (op_i)
      ALU_MUL:  res_o = acc_q;
      ALU_DIVU: res_o = x_q;
      ALU_REMU: res_o = acc_q;
      default:  res_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, EX/MEM forwarding, single-cycle ALU and the
// iterative mul/div unit, which stalls decode/fetch while it works.
module ex_stage
  import ex_pkg::*;
#(
  parameter int MD_ITER = MD_ITER_DEF
) (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);
  idex_t       idex_q, idex_d;
  logic        stall;
  logic [31:0] fwd_a, fwd_b, op_b, alu_res, md_res;

  // Stall has priority over flush: a busy mul/div keeps its instruction.
  always_comb begin
    idex_d = idex_q;
    if (!stall) begin
      if (bus.id_flush) begin
        idex_d = '0;
      end else begin
        idex_d.wreg       = bus.id_wreg;
        idex_d.m2reg      = bus.id_m2reg;
        idex_d.wmem       = bus.id_wmem;
        idex_d.aluc       = bus.id_aluc;
        idex_d.aluimm     = bus.id_aluimm;
        idex_d.inA        = bus.id_inA;
        idex_d.inB        = bus.id_inB;
        idex_d.imm        = bus.id_imm;
        idex_d.srcA       = bus.id_srcA;
        idex_d.srcB       = bus.id_srcB;
        idex_d.destR      = bus.id_destR;
        idex_d.ins_type   = bus.ID_ins_type;
        idex_d.ins_number = bus.ID_ins_number;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign fwd_a = (bus.mem_wreg && bus.mem_destR != 5'd0 && bus.mem_destR == idex_q.srcA)
               ? bus.mem_aluR : idex_q.inA;
  assign fwd_b = (bus.mem_wreg && bus.mem_destR != 5'd0 && bus.mem_destR == idex_q.srcB)
               ? bus.mem_aluR : idex_q.inB;
  assign op_b  = idex_q.aluimm ? idex_q.imm : fwd_b;

  md_unit #(.MD_ITER(MD_ITER)) u_md (
    .clk     (clk),
    .rst     (rst),
    .op_i    (idex_q.aluc),
    .a_i     (fwd_a),
    .b_i     (op_b),
    .stall_o (stall),
    .res_o   (md_res)
  );

  // Shifts move operand B by the amount in operand A.
  always_comb begin
    alu_res = '0;
    case (idex_q.aluc)
      ALU_ADD:  alu_res = fwd_a + op_b;
      ALU_SUB:  alu_res = fwd_a - op_b;
      ALU_AND:  alu_res = fwd_a & op_b;
      ALU_OR:   alu_res = fwd_a | op_b;
      ALU_XOR:  alu_res = fwd_a ^ op_b;
      ALU_NOR:  alu_res = ~(fwd_a | op_b);
      ALU_SLT:  alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
      ALU_SLL:  alu_res = op_b << fwd_a[4:0];
      ALU_SRL:  alu_res = op_b >> fwd_a[4:0];
      ALU_SRA:  alu_res = $signed(op_b) >>> fwd_a[4:0];
      ALU_LUI:  alu_res = {op_b[15:0], 16'h0};
      ALU_MUL,
      ALU_DIVU,
      ALU_REMU: alu_res = md_res;
      default:  alu_res = '0;
    endcase
  end

  assign bus.ex_stall       = stall;
  assign bus.ex_wreg        = idex_q.wreg  & ~stall;
  assign bus.ex_m2reg       = idex_q.m2reg & ~stall;
  assign bus.ex_wmem        = idex_q.wmem  & ~stall;
  assign bus.ex_aluR        = alu_res;
  assign bus.ex_zero        = (alu_res == 32'd0);
  assign bus.ex_destR       = idex_q.destR;
  assign bus.ex_inB         = fwd_b;
  assign bus.EXE_ins_type   = idex_q.ins_type;
  assign bus.EXE_ins_number = idex_q.ins_number;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: an instruction-level model checked every cycle,
// plus literal expectations for ALU vectors, forwarding, mul/div, reset, flush.
module tb_ex_stage;
  import ex_pkg::*;

  localparam int ITER = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_stage_if bus ();
  ex_stage #(.MD_ITER(ITER)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks = 0;
  int   fails  = 0;
  logic cmp_on = 1'b0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t vt [15] = '{
    '{4'd0,  32'd5,        32'd7,        32'd12},
    '{4'd1,  32'd3,        32'd5,        32'hFFFF_FFFE},
    '{4'd2,  32'hF0F0,     32'hFF00,     32'hF000},
    '{4'd3,  32'hF0F0,     32'h0F0F,     32'hFFFF},
    '{4'd4,  32'hFFFF,     32'h00FF,     32'hFF00},
    '{4'd5,  32'd0,        32'd0,        32'hFFFF_FFFF},
    '{4'd6,  32'hFFFF_FFFF,32'd1,        32'd1},
    '{4'd6,  32'd1,        32'hFFFF_FFFF,32'd0},
    '{4'd7,  32'h21,       32'd1,        32'd2},
    '{4'd8,  32'd4,        32'h8000_0000,32'h0800_0000},
    '{4'd9,  32'd4,        32'h8000_0000,32'hF800_0000},
    '{4'd10, 32'd0,        32'hABCD_1234,32'h1234_0000},
    '{4'd0,  32'hFFFF_FFFF,32'd1,        32'd0},
    '{4'd14, 32'd3,        32'd4,        32'd0},
    '{4'd15, 32'd3,        32'd4,        32'd0}
  };

  // Model: the instruction the stage should currently hold, and how many
  // cycles it has been held.
  logic [2:0]  m_ctl;
  logic [3:0]  m_op, m_ty, m_num;
  logic        m_isel;
  logic [31:0] m_a, m_b, m_imm, m_mda, m_mdb;
  logic [4:0]  m_sa, m_sb, m_dr;
  int          m_age;

  function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] v);
    return (bus.mem_wreg && bus.mem_destR != 5'd0 && bus.mem_destR == s) ? bus.mem_aluR : v;
  endfunction

  function automatic logic m_stall();
    return (m_op >= 4'd11 && m_op <= 4'd13) && (m_age <= ITER);
  endfunction

  function automatic logic [31:0] m_opb();
    return m_isel ? m_imm : fwd(m_sb, m_b);
  endfunction

  function automatic logic [31:0] m_res();
    logic [31:0] a, b;
    a = fwd(m_sa, m_a);
    b = m_opb();
    case (m_op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return b << a[4:0];
      4'd8:  return b >> a[4:0];
      4'd9:  return 32'($signed(b) >>> a[4:0]);
      4'd10: return {b[15:0], 16'h0};
      4'd11: return m_mda * m_mdb;
      4'd12: return (m_mdb == 0) ? 32'hFFFF_FFFF : m_mda / m_mdb;
      4'd13: return (m_mdb == 0) ? m_mda : m_mda % m_mdb;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ctl <= '0; m_op <= '0; m_ty <= '0; m_num <= '0; m_isel <= 1'b0;
      m_a <= '0; m_b <= '0; m_imm <= '0; m_mda <= '0; m_mdb <= '0;
      m_sa <= '0; m_sb <= '0; m_dr <= '0; m_age <= 0;
    end else if (!m_stall()) begin
      m_age  <= 0;
      m_ctl  <= bus.id_flush ? 3'b000 : {bus.id_wreg, bus.id_m2reg, bus.id_wmem};
      m_op   <= bus.id_flush ? 4'd0  : bus.id_aluc;
      m_isel <= bus.id_flush ? 1'b0  : bus.id_aluimm;
      m_a    <= bus.id_flush ? 32'd0 : bus.id_inA;
      m_b    <= bus.id_flush ? 32'd0 : bus.id_inB;
      m_imm  <= bus.id_flush ? 32'd0 : bus.id_imm;
      m_sa   <= bus.id_flush ? 5'd0  : bus.id_srcA;
      m_sb   <= bus.id_flush ? 5'd0  : bus.id_srcB;
      m_dr   <= bus.id_flush ? 5'd0  : bus.id_destR;
      m_ty   <= bus.id_flush ? 4'd0  : bus.ID_ins_type;
      m_num  <= bus.id_flush ? 4'd0  : bus.ID_ins_number;
    end else begin
      m_age <= m_age + 1;
      if (m_age == 0) begin
        m_mda <= fwd(m_sa, m_a);
        m_mdb <= m_opb();
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic        st;
    logic [31:0] r;
    st = m_stall();
    r  = m_res();
    chk("m_stall", 32'(bus.ex_stall), 32'(st));
    chk("m_ctl", 32'({bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem}), st ? 32'd0 : 32'(m_ctl));
    chk("m_destR", 32'(bus.ex_destR), 32'(m_dr));
    chk("m_inB", bus.ex_inB, fwd(m_sb, m_b));
    chk("m_tags", 32'({bus.EXE_ins_type, bus.EXE_ins_number}), 32'({m_ty, m_num}));
    if (!st) begin
      chk("m_aluR", bus.ex_aluR, r);
      chk("m_zero", 32'(bus.ex_zero), 32'(r == 32'd0));
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, b, imm, input logic isel,
                       input logic [4:0] sa, sb, dr, input logic [2:0] ctl, input logic fl,
                       input logic [3:0] ty, num);
    {bus.id_wreg, bus.id_m2reg, bus.id_wmem} = ctl;
    bus.id_aluc = op;   bus.id_inA = a;       bus.id_inB = b;
    bus.id_imm = imm;   bus.id_aluimm = isel; bus.id_srcA = sa;
    bus.id_srcB = sb;   bus.id_destR = dr;    bus.id_flush = fl;
    bus.ID_ins_type = ty; bus.ID_ins_number = num;
  endtask

  task automatic nop();
    drive(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction and check the ALU result in its first EX cycle.
  task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a, b,
                       input logic [31:0] e, input logic [4:0] sa, sb);
    drive(op, a, b, 32'd0, 1'b0, sa, sb, 5'd7, 3'b111, 1'b0, 4'd1, 4'd2);
    step();
    nop();
    @(negedge clk);
    chk(nm, bus.ex_aluR, e);
    chk({nm, "_zero"}, 32'(bus.ex_zero), 32'(e == 32'd0));
  endtask

  task automatic run_md(input string nm, input logic [3:0] op, input logic [31:0] a, b,
                        input logic [31:0] e, input logic fl_busy);
    int n;
    drive(op, a, b, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9, 3'b100, 1'b0, 4'd3, 4'd4);
    step();
    nop();
    n = 0;
    @(negedge clk);
    while (bus.ex_stall && n < 200) begin
      n++;
      if (fl_busy) begin
        bus.id_flush = 1'b1; bus.id_wreg = 1'b1; bus.ID_ins_type = 4'hF;
      end
      @(negedge clk);
    end
    chk({nm, "_stall_cycles"}, 32'(n), 32'(ITER + 1));
    chk(nm, bus.ex_aluR, e);
    chk({nm, "_wreg"}, 32'(bus.ex_wreg), 32'd1);
    chk({nm, "_tags"}, 32'({bus.EXE_ins_type, bus.EXE_ins_number}), 32'h34);
    @(negedge clk);
    chk({nm, "_wreg_once"}, 32'(bus.ex_wreg), 32'd0);
    nop();
  endtask

  initial begin
    nop();
    bus.mem_wreg = 1'b0; bus.mem_destR = 5'd0; bus.mem_aluR = 32'd0;
    fork
      forever begin
        @(negedge clk);
        if (cmp_on && rst) compare();
      end
    join_none

    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(bus.ex_stall), 32'd0);
    chk("rst_aluR", bus.ex_aluR, 32'd0);
    chk("rst_zero", 32'(bus.ex_zero), 32'd1);
    chk("rst_ctl", 32'({bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem}), 32'd0);
    chk("rst_destR_inB", 32'(bus.ex_destR) | bus.ex_inB, 32'd0);
    chk("rst_tags", 32'({bus.EXE_ins_type, bus.EXE_ins_number}), 32'd0);
    #1 rst = 1'b1;
    cmp_on = 1'b1;
    step();

    for (int i = 0; i < 15; i++)
      issue($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].e, 5'd0, 5'd0);

    // Immediate operand B; ex_inB still carries the register value.
    drive(4'd0, 32'h10, 32'h999, 32'h20, 1'b1, 5'd0, 5'd0, 5'd2, 3'b010, 1'b0, 4'd0, 4'd0);
    step(); nop();
    @(negedge clk);
    chk("imm_aluR", bus.ex_aluR, 32'h30);
    chk("imm_inB", bus.ex_inB, 32'h999);

    // Forwarding from EX/MEM.
    bus.mem_wreg = 1'b1; bus.mem_destR = 5'd3; bus.mem_aluR = 32'h100;
    issue("fwd_a_sub", 4'd1, 32'h55, 32'h100, 32'd0, 5'd3, 5'd0);
    issue("fwd_b_add", 4'd0, 32'd1, 32'h77, 32'h101, 5'd0, 5'd3);
    chk("fwd_b_inB", bus.ex_inB, 32'h100);
    bus.mem_wreg = 1'b0;
    issue("nofwd_wreg0", 4'd1, 32'h55, 32'h100, 32'hFFFF_FF55, 5'd3, 5'd0);
    bus.mem_wreg = 1'b1; bus.mem_destR = 5'd0;
    issue("nofwd_r0", 4'd0, 32'd2, 32'd3, 32'd5, 5'd0, 5'd0);
    bus.mem_wreg = 1'b0;

    run_md("mul_wrap", 4'd11, 32'h1_0000, 32'h1_0000, 32'd0, 1'b0);
    run_md("mul", 4'd11, 32'h1_2345, 32'h100, 32'h123_4500, 1'b0);
    run_md("divu", 4'd12, 32'd100, 32'd7, 32'd14, 1'b0);
    run_md("remu", 4'd13, 32'd100, 32'd7, 32'd2, 1'b0);
    run_md("divu_zero", 4'd12, 32'd55, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_md("remu_zero", 4'd13, 32'd55, 32'd0, 32'd55, 1'b0);
    run_md("divu_flush_busy", 4'd12, 32'd100, 32'd7, 32'd14, 1'b1);

    // Flush while idle.
    drive(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd0, 5'd0, 5'd6, 3'b111, 1'b1, 4'd5, 4'd6);
    step(); nop();
    @(negedge clk);
    chk("flush_ctl", 32'({bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem}), 32'd0);
    chk("flush_tags", 32'({bus.EXE_ins_type, bus.EXE_ins_number}), 32'd0);
    chk("flush_destR", 32'(bus.ex_destR), 32'd0);

    // Reset during BUSY cycle 10 abandons the multiply.
    drive(4'd11, 32'd3, 32'd5, 32'd0, 1'b0, 5'd0, 5'd0, 5'd4, 3'b100, 1'b0, 4'd3, 4'd4);
    step(); nop();
    repeat (11) @(negedge clk);
    chk("pre_rst_stall", 32'(bus.ex_stall), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_stall", 32'(bus.ex_stall), 32'd0);
    chk("midrst_fsm", 32'(dut.u_md.state_q), 32'(MD_IDLE));
    chk("midrst_aluR", bus.ex_aluR, 32'd0);
    chk("midrst_zero", 32'(bus.ex_zero), 32'd1);
    chk("midrst_wreg", 32'(bus.ex_wreg), 32'd0);
    #1 rst = 1'b1;
    issue("add_after_rst", 4'd0, 32'd5, 32'd7, 32'd12, 5'd0, 5'd0);
    chk("add_after_rst_stall", 32'(bus.ex_stall), 32'd0);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
